// File: rtl/ifu_fetch.sv
`default_nettype none
// ifu_fetch: single-outstanding instruction fetch stage owning the PC, with a valid/ready
// memory request channel, decode handshake, and redirect handling that discards stale fetches.
module ifu_fetch #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump,
  input  logic [DATA_WIDTH-1:0] upc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                  mem_rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  output logic                  fetch_err
);

  localparam logic [DATA_WIDTH-1:0] c_PC_STEP    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] c_ALIGN_MASK = DATA_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_inst;
  logic [DATA_WIDTH-1:0] r_inst_pc;
  logic                  r_fetch_err;
  logic                  r_req_valid;
  logic                  r_inst_valid;
  logic [DATA_WIDTH-1:0] w_upc_aligned;

  assign w_upc_aligned = upc & ~c_ALIGN_MASK;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_fetch_err  <= 1'b0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state     <= S_REQ;
          r_req_valid <= 1'b1;
        end
        S_REQ: begin
          // A redirect may retarget a pending request; if it was also accepted, the
          // old-address response is still owed and must be swallowed in DROP.
          if (jump) begin
            r_pc <= w_upc_aligned;
            if (mem_req_ready) begin
              r_state     <= S_DROP;
              r_req_valid <= 1'b0;
            end
          end else if (mem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid && !jump) begin
            r_inst       <= mem_rsp_data;
            r_inst_pc    <= r_pc;
            r_fetch_err  <= mem_rsp_err;
            r_pc         <= r_pc + c_PC_STEP;
            r_state      <= S_HOLD;
            r_inst_valid <= 1'b1;
          end else if (mem_rsp_valid) begin
            r_pc        <= w_upc_aligned;
            r_state     <= S_REQ;
            r_req_valid <= 1'b1;
          end else if (jump) begin
            r_pc    <= w_upc_aligned;
            r_state <= S_DROP;
          end
        end
        S_HOLD: begin
          if (jump) begin
            r_pc         <= w_upc_aligned;
            r_state      <= S_REQ;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b1;
          end else if (inst_ready) begin
            r_state      <= S_REQ;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b1;
          end
        end
        S_DROP: begin
          if (jump) begin
            r_pc <= w_upc_aligned;
          end
          if (mem_rsp_valid) begin
            r_state     <= S_REQ;
            r_req_valid <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_pc;
  assign inst_valid    = r_inst_valid;
  assign inst          = r_inst;
  assign inst_pc       = r_inst_pc;
  assign fetch_err     = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// tb_ifu_fetch: scoreboard bench for ifu_fetch with a latency-programmable memory responder
// and a second instance at a wrapping reset PC.
module tb_ifu_fetch;

  localparam logic [31:0] c_KEY = 32'h5A5A_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        jump;
  logic [31:0] upc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_err;

  logic        w2_req_valid;
  logic        w2_req_ready;
  logic [31:0] w2_req_addr;
  logic        w2_rsp_valid;
  logic [31:0] w2_rsp_data;
  logic        w2_rsp_err;
  logic        w2_inst_valid;
  logic        w2_inst_ready;
  logic [31:0] w2_inst;
  logic [31:0] w2_inst_pc;
  logic        w2_fetch_err;
  logic        w2_jump;
  logic [31:0] w2_upc;

  int          lat;
  logic        xor_mode;
  logic [31:0] fix_data;
  logic        r_pend;
  int          r_cnt;
  logic [31:0] r_addr;

  exp_t        sb[$];
  int          n_checks;
  int          n_fails;
  logic        p_v, p_rdy, p_jump;

  ifu_fetch dut (
    .clk(clk), .rst(rst), .jump(jump), .upc(upc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .fetch_err(fetch_err)
  );

  ifu_fetch #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .jump(w2_jump), .upc(w2_upc),
    .mem_req_valid(w2_req_valid), .mem_req_ready(w2_req_ready), .mem_req_addr(w2_req_addr),
    .mem_rsp_valid(w2_rsp_valid), .mem_rsp_data(w2_rsp_data), .mem_rsp_err(w2_rsp_err),
    .inst_valid(w2_inst_valid), .inst_ready(w2_inst_ready), .inst(w2_inst), .inst_pc(w2_inst_pc),
    .fetch_err(w2_fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: one response lat cycles after each accepted request.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= 1'b0;
      r_cnt  <= 0;
      r_addr <= '0;
    end else if (mem_req_valid && mem_req_ready) begin
      r_pend <= 1'b1;
      r_cnt  <= lat - 1;
      r_addr <= mem_req_addr;
    end else if (r_pend) begin
      if (r_cnt == 0) r_pend <= 1'b0;
      else            r_cnt  <= r_cnt - 1;
    end
  end

  assign mem_rsp_valid = r_pend && (r_cnt == 0);
  assign mem_rsp_data  = xor_mode ? (r_addr ^ c_KEY) : fix_data;
  assign mem_rsp_err   = 1'b0;

  // Scoreboard: every new presentation to decode must match the oldest expectation.
  initial begin
    exp_t e;
    p_v = 1'b0; p_rdy = 1'b0; p_jump = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (inst_valid && !(p_v && !p_rdy && !p_jump)) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fails++;
            $display("FAIL sb_unexpected: got pc=%h inst=%h, required no instruction", inst_pc, inst);
          end else begin
            e = sb.pop_front();
            if (inst_pc !== e.pc || inst !== e.data || fetch_err !== e.err) begin
              n_fails++;
              $display("FAIL sb_inst: got pc=%h inst=%h err=%b, required pc=%h inst=%h err=%b",
                       inst_pc, inst, fetch_err, e.pc, e.data, e.err);
            end
          end
        end
        p_v = inst_valid; p_rdy = inst_ready; p_jump = jump;
      end else begin
        p_v = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] d, input logic err);
    exp_t e;
    e.pc = pc; e.data = d; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (inst_valid) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fails++;
      $display("FAIL %s_timeout: got inst_valid=0, required 1 within 40 cycles", name);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; jump = 1'b0; upc = '0; inst_ready = 1'b0; mem_req_ready = 1'b0;
    lat = 1; xor_mode = 1'b1; fix_data = 32'h0000_0013;
    w2_req_ready = 1'b0; w2_rsp_valid = 1'b0; w2_rsp_data = '0; w2_rsp_err = 1'b0;
    w2_inst_ready = 1'b0;
    sb.delete();
    cyc(); cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 ||
        fetch_err !== 1'b0 || mem_req_addr !== 32'h8000_0000) begin
      n_fails++;
      $display("FAIL reset_values: got rv=%b iv=%b inst=%h ipc=%h err=%b addr=%h, required 0 0 0 0 0 80000000",
               mem_req_valid, inst_valid, inst, inst_pc, fetch_err, mem_req_addr);
    end
    cyc();
    rst = 1'b1;
    cyc();
    n_checks++;
    if (mem_req_valid !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_first_req: got mem_req_valid=%b, required 1", mem_req_valid);
    end
  endtask

  task automatic test_free_run();
    int cnt;
    do_reset();
    mem_req_ready = 1'b1; inst_ready = 1'b1; xor_mode = 1'b0;
    push_exp(32'h8000_0000, 32'h0000_0013, 1'b0);
    push_exp(32'h8000_0004, 32'h0000_0013, 1'b0);
    push_exp(32'h8000_0008, 32'h0000_0013, 1'b0);
    cyc();
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin
      n_fails++;
      $display("FAIL free_first_req: got rv=%b addr=%h, required 1 80000000", mem_req_valid, mem_req_addr);
    end
    cyc();
    cyc();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0000) begin
      n_fails++;
      $display("FAIL free_latency: got iv=%b pc=%h at edge 3, required 1 80000000", inst_valid, inst_pc);
    end
    for (int k = 0; k < 2; k++) begin
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
        cyc();
        cnt++;
        if (inst_valid) break;
      end
      if (k == 1) inst_ready = 1'b0;
      n_checks++;
      if (cnt != 3) begin
        n_fails++;
        $display("FAIL free_spacing: got %0d cycles, required 3", cnt);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL free_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_req_ready = 1'b1;
    push_exp(32'h8000_0000, 32'h8000_0000 ^ c_KEY, 1'b0);
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++;
      if (inst_valid !== 1'b1 || mem_req_valid !== 1'b0 || inst_pc !== 32'h8000_0000 ||
          inst !== (32'h8000_0000 ^ c_KEY)) begin
        n_fails++;
        $display("FAIL bp_stable: got iv=%b rv=%b pc=%h inst=%h, required 1 0 80000000 %h",
                 inst_valid, mem_req_valid, inst_pc, inst, 32'h8000_0000 ^ c_KEY);
      end
    end
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0004) begin
      n_fails++;
      $display("FAIL bp_next_req: got rv=%b addr=%h, required 1 80000004", mem_req_valid, mem_req_addr);
    end
    push_exp(32'h8000_0004, 32'h8000_0004 ^ c_KEY, 1'b0);
    wait_valid("bp2");
    @(negedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL bp_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_redirect_wait();
    bit seen = 0;
    do_reset();
    mem_req_ready = 1'b1; lat = 4; xor_mode = 1'b0; fix_data = 32'hDEAD_BEEF;
    cyc();
    cyc();
    jump = 1'b1; upc = 32'h8000_0103;
    cyc();
    jump = 1'b0;
    n_checks++;
    if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || mem_req_addr !== 32'h8000_0100) begin
      n_fails++;
      $display("FAIL rw_drop: got rv=%b iv=%b addr=%h, required 0 0 80000100",
               mem_req_valid, inst_valid, mem_req_addr);
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      if (mem_req_valid) seen = 1;
    end
    n_checks++;
    if (!seen || mem_req_addr !== 32'h8000_0100) begin
      n_fails++;
      $display("FAIL rw_new_req: got seen=%b addr=%h, required 1 80000100", seen, mem_req_addr);
    end
    xor_mode = 1'b1; lat = 1;
    push_exp(32'h8000_0100, 32'h8000_0100 ^ c_KEY, 1'b0);
    wait_valid("rw");
    @(negedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL rw_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_redirect_req();
    do_reset();
    xor_mode = 1'b0; fix_data = 32'hDEAD_BEEF;
    cyc();
    jump = 1'b1; upc = 32'h8000_0400;
    cyc();
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0400) begin
      n_fails++;
      $display("FAIL rq_retarget: got rv=%b addr=%h, required 1 80000400", mem_req_valid, mem_req_addr);
    end
    upc = 32'h8000_0301; mem_req_ready = 1'b1;
    cyc();
    jump = 1'b0;
    n_checks++;
    if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h8000_0300) begin
      n_fails++;
      $display("FAIL rq_drop: got rv=%b addr=%h, required 0 80000300", mem_req_valid, mem_req_addr);
    end
    cyc();
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0300) begin
      n_fails++;
      $display("FAIL rq_reissue: got rv=%b addr=%h, required 1 80000300", mem_req_valid, mem_req_addr);
    end
    xor_mode = 1'b1;
    push_exp(32'h8000_0300, 32'h8000_0300 ^ c_KEY, 1'b0);
    wait_valid("rq");
    @(negedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL rq_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_jump_hold();
    do_reset();
    mem_req_ready = 1'b1;
    push_exp(32'h8000_0000, 32'h8000_0000 ^ c_KEY, 1'b0);
    wait_valid("jh");
    jump = 1'b1; upc = 32'h8000_0202; inst_ready = 1'b1;
    cyc();
    jump = 1'b0; inst_ready = 1'b0;
    n_checks++;
    if (mem_req_valid !== 1'b1 || inst_valid !== 1'b0 || mem_req_addr !== 32'h8000_0200) begin
      n_fails++;
      $display("FAIL jh_redirect: got rv=%b iv=%b addr=%h, required 1 0 80000200",
               mem_req_valid, inst_valid, mem_req_addr);
    end
    push_exp(32'h8000_0200, 32'h8000_0200 ^ c_KEY, 1'b0);
    wait_valid("jh2");
    @(negedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL jh_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_err_wrap();
    do_reset();
    w2_req_ready = 1'b1;
    cyc();
    n_checks++;
    if (w2_req_valid !== 1'b1 || w2_req_addr !== 32'hFFFF_FFFC) begin
      n_fails++;
      $display("FAIL ew_first_req: got rv=%b addr=%h, required 1 fffffffc", w2_req_valid, w2_req_addr);
    end
    cyc();
    w2_rsp_valid = 1'b1; w2_rsp_data = 32'h0010_0073; w2_rsp_err = 1'b1;
    cyc();
    w2_rsp_valid = 1'b0; w2_rsp_err = 1'b0;
    n_checks++;
    if (w2_inst_valid !== 1'b1 || w2_inst_pc !== 32'hFFFF_FFFC || w2_fetch_err !== 1'b1 ||
        w2_inst !== 32'h0010_0073) begin
      n_fails++;
      $display("FAIL ew_err_inst: got iv=%b pc=%h err=%b inst=%h, required 1 fffffffc 1 00100073",
               w2_inst_valid, w2_inst_pc, w2_fetch_err, w2_inst);
    end
    w2_inst_ready = 1'b1;
    cyc();
    w2_inst_ready = 1'b0;
    n_checks++;
    if (w2_req_valid !== 1'b1 || w2_req_addr !== 32'h0) begin
      n_fails++;
      $display("FAIL ew_wrap_req: got rv=%b addr=%h, required 1 00000000", w2_req_valid, w2_req_addr);
    end
    cyc();
    w2_rsp_valid = 1'b1; w2_rsp_data = 32'h0000_0013;
    cyc();
    w2_rsp_valid = 1'b0;
    n_checks++;
    if (w2_inst_valid !== 1'b1 || w2_inst_pc !== 32'h0 || w2_fetch_err !== 1'b0 ||
        w2_inst !== 32'h0000_0013) begin
      n_fails++;
      $display("FAIL ew_wrap_inst: got iv=%b pc=%h err=%b inst=%h, required 1 00000000 0 00000013",
               w2_inst_valid, w2_inst_pc, w2_fetch_err, w2_inst);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_req_ready = 1'b1; inst_ready = 1'b1;
    push_exp(32'h8000_0000, 32'h8000_0000 ^ c_KEY, 1'b0);
    wait_valid("ar");
    lat = 4;
    cyc();
    cyc();
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 ||
        fetch_err !== 1'b0 || mem_req_addr !== 32'h8000_0000) begin
      n_fails++;
      $display("FAIL ar_async: got rv=%b iv=%b inst=%h pc=%h err=%b addr=%h, required 0 0 0 0 0 80000000",
               mem_req_valid, inst_valid, inst, inst_pc, fetch_err, mem_req_addr);
    end
    cyc();
    rst = 1'b1; lat = 1; inst_ready = 1'b0;
    sb.delete();
    push_exp(32'h8000_0000, 32'h8000_0000 ^ c_KEY, 1'b0);
    cyc();
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin
      n_fails++;
      $display("FAIL ar_restart: got rv=%b addr=%h, required 1 80000000", mem_req_valid, mem_req_addr);
    end
    wait_valid("ar2");
    @(negedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL ar_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    rst = 1'b0; jump = 1'b0; upc = '0; inst_ready = 1'b0; mem_req_ready = 1'b0;
    lat = 1; xor_mode = 1'b1; fix_data = '0;
    w2_jump = 1'b0; w2_upc = '0; w2_req_ready = 1'b0; w2_rsp_valid = 1'b0;
    w2_rsp_data = '0; w2_rsp_err = 1'b0; w2_inst_ready = 1'b0;
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect_wait();
    test_redirect_req();
    test_jump_hold();
    test_err_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch stage that sits directly upstream of the decode/execute core. It owns the program counter, issues one instruction-memory read at a time over a valid/ready request channel, and captures the response. It presents each fetched word to decode with a valid/ready handshake and accepts redirects (`jump`/`upc`) from the execute stage, discarding any in-flight or held instruction made stale by a redirect.

## Interface
- `DATA_WIDTH`, 32: width of PC, address and instruction.
- `RESET_PC`, 32'h8000_0000: PC value loaded on reset.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset: asserted at 0, released at 1.
- `jump`  in  1  redirect request from execute stage.
- `upc`  in  DATA_WIDTH  redirect target; bits [1:0] ignored (treated as 0).
- `mem_req_valid`  out  1  read request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_addr`  out  DATA_WIDTH  read address (= internal `pc`).
- `mem_rsp_valid`  in  1  read data valid (one pulse per accepted request).
- `mem_rsp_data`  in  DATA_WIDTH  instruction word.
- `mem_rsp_err`  in  1  access fault for this response.
- `inst_valid`  out  1  `inst` holds a fetched instruction.
- `inst_ready`  in  1  decode consumes `inst`.
- `inst`  out  DATA_WIDTH  fetched instruction.
- `inst_pc`  out  DATA_WIDTH  address `inst` was fetched from.
- `fetch_err`  out  1  `mem_rsp_err` captured with `inst`.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DROP. At most one request outstanding.
- Reset (`rst`=0, async): state=IDLE, `pc`=RESET_PC, `inst`=0, `inst_pc`=0, `fetch_err`=0; `inst_valid`=0, `mem_req_valid`=0.
- `mem_req_valid` = (state==REQ); `inst_valid` = (state==HOLD); `mem_req_addr` = `pc`.
- IDLE: go to REQ unconditionally.
- REQ:
  - `jump`=1 and `mem_req_ready`=0: `pc`<=`upc`&~3, stay REQ. Address may change while valid only under redirect.
  - `jump`=1 and `mem_req_ready`=1: `pc`<=`upc`&~3, go to DROP. The request for the old pc was accepted and its response must be discarded.
  - `mem_req_ready`=1 without jump: go to WAIT.
- WAIT:
  - `mem_rsp_valid`=1 without jump: `inst`<=data, `inst_pc`<=`pc`, `fetch_err`<=err, `pc`<=`pc`+4, go to HOLD.
  - `mem_rsp_valid`=1 with jump: discard the response, `pc`<=`upc`&~3, go to REQ.
  - `jump` without response: `pc`<=`upc`&~3, go to DROP.
- HOLD:
  - `jump`=1: discard the held instruction, `pc`<=`upc`&~3, go to REQ. Jump wins over `inst_ready`.
  - `inst_ready`=1: go to REQ.
  - Otherwise hold `inst`/`inst_pc`/`fetch_err` stable.
- DROP:
  - `mem_rsp_valid`=1: discard the response and go to REQ. If `jump` is also 1, `pc`<=`upc`&~3.
  - `jump` alone: update `pc`, stay DROP.
- `mem_rsp_valid` in IDLE, REQ or HOLD is a protocol error: ignore it, no state change.
- `pc`+4 wraps modulo 2^DATA_WIDTH (32'hFFFF_FFFC -> 0).
- A fetch error does not stop fetching. The instruction is delivered with `fetch_err`=1, and exception handling belongs downstream.

## Timing
- All state, `pc` and output registers update on the rising `clk` edge. Reset is asynchronous on assertion; release takes effect at the next edge.
- Minimum latency from reset release:
  - edge 1: IDLE -> REQ.
  - edge 2: request handshake.
  - edge 3: response captured (1-cycle memory).
  - `inst_valid`=1 in the cycle after edge 3.
- Peak throughput is one instruction per 3 cycles (REQ, WAIT, HOLD) with zero-wait memory and `inst_ready`=1.
- Redirect latency: the first request to `upc` is issued in the cycle after `jump` (from HOLD/WAIT+rsp). From DROP, it is issued after the stale response arrives.
- Reset asserted mid-transaction abandons any outstanding request. Memory is reset by the same `rst`.

## Test plan
- Reset then free-run: `mem_rsp_data` = 32'h00000013, ready=1, 1-cycle memory -> `inst_pc` = 80000000, 80000004, 80000008 on successive `inst_valid` pulses 3 cycles apart; `fetch_err`=0.
- Backpressure: hold `inst_ready`=0 for 5 cycles in HOLD -> `inst`/`inst_pc` stable, `mem_req_valid`=0; the next request is issued the cycle after `inst_ready`=1.
- Redirect in WAIT: `jump`=1, `upc`=32'h80000103 with no response -> DROP. The late response 32'hDEADBEEF is never presented. The next `mem_req_addr`=32'h80000100 and `inst_pc`=80000100.
- Redirect vs ready in HOLD: `jump`=1 and `inst_ready`=1 in the same cycle -> held instruction discarded, next request to `upc`.
- Error and wrap: `RESET_PC`=32'hFFFF_FFFC with `mem_rsp_err`=1 on the first fetch -> `inst_pc`=FFFFFFFC with `fetch_err`=1, then `inst_pc`=0 with `fetch_err`=0.
- Async reset asserted in WAIT -> outputs reach reset values without a clock edge, and after release the first `mem_req_addr`=`RESET_PC`.
